debug_reg_dump: RTL and testbench

- Debug-side reader for the decode stage's register-file debug read port.
- On request, it walks register addresses 0..NUM_REGS-1 on the debug select bus and captures each 32-bit value.
- It serialises each value into bytes, LSB first, and hands them one at a time to the UART transmitter through a start/done handshake.
- It sits between the debug unit command FSM and uart_tx.

---
 rtl/debug_reg_dump.sv | 168 ++++++++++++++++
 tb/tb_debug_reg_dump.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_reg_dump.sv
// -----------------------------------------------------------------------------
// debug_reg_dump
//
// Walks register addresses 0..NUM_REGS-1 on the register-file debug read
// port. It captures each NB-bit value and sends it to the UART transmitter
// one byte at a time, least-significant byte first.
//
// Ports
//   i_clk             system clock, rising edge
//   i_reset           asynchronous active-high reset
//   i_start           dump request pulse (only honoured in IDLE)
//   o_select_reg_dir  register address to the register-file debug port
//   i_reg_data        read data for o_select_reg_dir
//   o_tx_data         byte presented to the UART transmitter
//   o_tx_start        one-cycle pulse, o_tx_data valid in that cycle
//   i_tx_done         UART byte-sent pulse (only honoured in WAIT_TX)
//   o_busy            high whenever the walker is not IDLE
//   o_done            one-cycle pulse after the last byte of the last register
// -----------------------------------------------------------------------------
module debug_reg_dump #(
  parameter int NB       = 32,
  parameter int REGS     = 5,
  parameter int NUM_REGS = 32,
  parameter int BYTE_NB  = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [REGS-1:0]    o_select_reg_dir,
  input  logic [NB-1:0]      i_reg_data,
  output logic [BYTE_NB-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam int BYTES = NB / BYTE_NB;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [REGS-1:0]  LAST_REG  = REGS'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t               state_reg, state_next;
  logic [REGS-1:0]      reg_idx_reg, reg_idx_next;
  logic [CNT_W-1:0]     byte_cnt_reg, byte_cnt_next;
  logic [NB-1:0]        shift_data_reg, shift_data_next;
  logic [BYTE_NB-1:0]   tx_data_reg, tx_data_next;
  logic                 tx_start_reg, tx_start_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      reg_idx_reg    <= '0;
      byte_cnt_reg   <= '0;
      shift_data_reg <= '0;
      tx_data_reg    <= '0;
      tx_start_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      reg_idx_reg    <= reg_idx_next;
      byte_cnt_reg   <= byte_cnt_next;
      shift_data_reg <= shift_data_next;
      tx_data_reg    <= tx_data_next;
      tx_start_reg   <= tx_start_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start) state_next = SELECT;
      SELECT:  state_next = CAPTURE;   // address settles for sync or async read
      CAPTURE: state_next = SEND;
      SEND:    state_next = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done) begin
          state_next = (byte_cnt_reg == LAST_BYTE) ? NEXT : SEND;
        end
      end
      NEXT:    state_next = (reg_idx_reg == LAST_REG) ? DONE : SELECT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_idx_next    = reg_idx_reg;
    byte_cnt_next   = byte_cnt_reg;
    shift_data_next = shift_data_reg;
    tx_data_next    = tx_data_reg;     // byte held stable while UART works
    tx_start_next   = 1'b0;
    done_next       = 1'b0;
    // Registered copy of "not IDLE", aligned with the state it describes.
    busy_next       = (state_next != IDLE);

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          reg_idx_next  = '0;
          byte_cnt_next = '0;
        end
      end
      CAPTURE: begin
        // Only sampling point of i_reg_data; later changes cannot leak in.
        shift_data_next = i_reg_data;
      end
      SEND: begin
        tx_data_next  = shift_data_reg[BYTE_NB-1:0];
        tx_start_next = 1'b1;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          if (byte_cnt_reg == LAST_BYTE) begin
            byte_cnt_next = '0;
          end else begin
            byte_cnt_next   = byte_cnt_reg + CNT_W'(1);
            shift_data_next = shift_data_reg >> BYTE_NB;
          end
        end
      end
      NEXT: begin
        if (reg_idx_reg == LAST_REG) begin
          // o_done lands in the DONE cycle, one cycle after the last NEXT.
          done_next = 1'b1;
        end else begin
          reg_idx_next = reg_idx_reg + REGS'(1);
        end
      end
      DONE: begin
        reg_idx_next = '0;
      end
      default: begin
      end
    endcase
  end

  assign o_select_reg_dir = reg_idx_reg;
  assign o_tx_data        = tx_data_reg;
  assign o_tx_start       = tx_start_reg;
  assign o_busy           = busy_reg;
  assign o_done           = done_reg;

endmodule

// File: tb/tb_debug_reg_dump.sv
// -----------------------------------------------------------------------------
// tb_debug_reg_dump
//
// Bench for debug_reg_dump. One instance uses the default 32-register
// configuration and one uses NUM_REGS=1. All stimulus is driven from a single
// initial block on the falling clock edge, and DUT outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_debug_reg_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main instance (32 registers)
  logic        start;
  logic [4:0]  sel;
  logic [31:0] reg_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic        done;
  logic        override;

  // Register model: 0x11223300 + address, or all-ones while corrupted
  assign reg_data = override ? 32'hFFFF_FFFF : (32'h1122_3300 + {27'd0, sel});

  debug_reg_dump #(.NB(32), .REGS(5), .NUM_REGS(32), .BYTE_NB(8)) u_dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_start          (start),
    .o_select_reg_dir (sel),
    .i_reg_data       (reg_data),
    .o_tx_data        (tx_data),
    .o_tx_start       (tx_start),
    .i_tx_done        (tx_done),
    .o_busy           (busy),
    .o_done           (done)
  );

  // Corner instance (single register)
  logic        start1;
  logic [4:0]  sel1;
  logic [31:0] reg_data1;
  logic [7:0]  tx_data1;
  logic        tx_start1;
  logic        tx_done1;
  logic        busy1;
  logic        done1;

  assign reg_data1 = 32'hDEAD_BEEF;

  debug_reg_dump #(.NB(32), .REGS(5), .NUM_REGS(1), .BYTE_NB(8)) u_dut1 (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_start          (start1),
    .o_select_reg_dir (sel1),
    .i_reg_data       (reg_data1),
    .o_tx_data        (tx_data1),
    .o_tx_start       (tx_start1),
    .i_tx_done        (tx_done1),
    .o_busy           (busy1),
    .o_done           (done1)
  );

  int checks   = 0;
  int failures = 0;

  // Observations from the most recent dump
  logic [7:0] got[$];
  int first_tx, done_k, done_cnt, hold_errs;
  bit busy_at_done, busy_after, corrupt_hit, timed_out, aborted;

  typedef struct {
    string tag;
    int    delay;      // cycles from o_tx_start to i_tx_done
    bit    spur;       // spurious i_tx_done / i_start
    bit    corrupt;    // i_reg_data forced to all-ones during reg 3 WAIT_TX
    int    exp_done;   // cycle of o_done, counted from the SELECT cycle
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] v;
    v = 32'h1122_3300 + 32'(i / 4);
    return v[8*(i%4) +: 8];
  endfunction

  // Runs one dump on the main instance; cycle k=0 is the SELECT cycle.
  task automatic run_dump(input int delay, input bit spur, input bit corrupt,
                          input int budget, input bit abort_mid);
    int  pend;
    bit  prev_tx, prev_done;
    logic [7:0] held;
    got.delete();
    first_tx = -1; done_k = -1; done_cnt = 0; hold_errs = 0;
    busy_at_done = 1'b0; busy_after = 1'b1; corrupt_hit = 1'b0;
    timed_out = 1'b1; aborted = 1'b0;
    pend = 0; prev_tx = 1'b0; prev_done = 1'b0; held = 8'h00;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tx_done = 1'b0;
      start   = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) tx_done = 1'b1;
      end
      if (tx_start) begin
        if (prev_tx) hold_errs++;          // start wider than one cycle
        got.push_back(tx_data);
        if (first_tx < 0) first_tx = k;
        held = tx_data;
        if (delay == 0) tx_done = 1'b1;
        else pend = delay;
      end else if (got.size() > 0 && tx_data !== held) begin
        hold_errs++;                       // byte changed between starts
      end
      prev_tx = tx_start;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        busy_at_done = busy;
      end
      if (prev_done) busy_after = busy;
      prev_done = done;
      if (spur && k < 352 && (k % 11) < 3) tx_done = 1'b1;  // SELECT/CAPTURE/SEND
      if (spur && k == 100) start = 1'b1;
      if (corrupt && tx_start && sel == 5'd3) begin
        override    = 1'b1;
        corrupt_hit = 1'b1;
      end
      if (sel != 5'd3) override = 1'b0;
      if (abort_mid && tx_start && got.size() == 23) begin
        aborted   = 1'b1;
        timed_out = 1'b0;
        break;
      end
      if (done_k >= 0 && k == done_k + 1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    tx_done  = 1'b0;
    start    = 1'b0;
    override = 1'b0;
  endtask

  task automatic check_dump(input string tag, input int exp_done);
    chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
    chk({tag, "_nbytes"}, 64'(got.size()), 64'd128);
    for (int i = 0; i < 128; i++) begin
      if (i < got.size())
        chk($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(exp_byte(i)));
    end
    chk({tag, "_first_tx_lat"}, 64'(first_tx), 64'd3);
    chk({tag, "_done_cycle"}, 64'(done_k), 64'(exp_done));
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd1);
    chk({tag, "_busy_after_done"}, 64'(busy_after), 64'd0);
    chk({tag, "_hold_errs"}, 64'(hold_errs), 64'd0);
  endtask

  vec_t vecs[5];
  logic [7:0] bytes1[$];
  logic [7:0] exp1[4];

  initial begin
    int d1k, d1cnt, tx_in_rst;
    bit sel_nz;

    vecs[0] = '{tag: "basic",   delay: 0,  spur: 1'b0, corrupt: 1'b0, exp_done: 352};
    vecs[1] = '{tag: "fast1",   delay: 1,  spur: 1'b0, corrupt: 1'b0, exp_done: 480};
    vecs[2] = '{tag: "slow20",  delay: 20, spur: 1'b0, corrupt: 1'b0, exp_done: 2912};
    vecs[3] = '{tag: "spur",    delay: 0,  spur: 1'b1, corrupt: 1'b0, exp_done: 352};
    vecs[4] = '{tag: "capture", delay: 1,  spur: 1'b0, corrupt: 1'b1, exp_done: 480};
    exp1[0] = 8'hEF; exp1[1] = 8'hBE; exp1[2] = 8'hAD; exp1[3] = 8'hDE;

    rst = 1'b1; start = 1'b0; tx_done = 1'b0; override = 1'b0;
    start1 = 1'b0; tx_done1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_sel",      64'(sel),      64'd0);
    chk("reset_tx_data",  64'(tx_data),  64'd0);
    chk("reset_tx_start", 64'(tx_start), 64'd0);
    chk("reset_busy",     64'(busy),     64'd0);
    chk("reset_done",     64'(done),     64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven dump scenarios
    for (int v = 0; v < 5; v++) begin
      run_dump(vecs[v].delay, vecs[v].spur, vecs[v].corrupt, vecs[v].exp_done + 50, 1'b0);
      check_dump(vecs[v].tag, vecs[v].exp_done);
      if (vecs[v].corrupt) chk({vecs[v].tag, "_corrupt_applied"}, 64'(corrupt_hit), 64'd1);
      repeat (3) @(negedge clk);
    end

    // Reset in the middle of byte 2 of register 5
    run_dump(0, 1'b0, 1'b0, 400, 1'b1);
    chk("abort_reached", 64'(aborted), 64'd1);
    chk("abort_sel_before", 64'(sel), 64'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sel",      64'(sel),      64'd0);
    chk("async_rst_tx_data",  64'(tx_data),  64'd0);
    chk("async_rst_tx_start", 64'(tx_start), 64'd0);
    chk("async_rst_busy",     64'(busy),     64'd0);
    chk("async_rst_done",     64'(done),     64'd0);
    tx_in_rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tx_start || busy) tx_in_rst++;
    end
    chk("rst_hold_quiet", 64'(tx_in_rst), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_dump(0, 1'b0, 1'b0, 402, 1'b0);
    check_dump("after_rst", 352);

    // Single-register configuration
    bytes1.delete();
    d1k = -1; d1cnt = 0; sel_nz = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tx_done1 = 1'b0;
      if (tx_start1) begin
        bytes1.push_back(tx_data1);
        tx_done1 = 1'b1;
      end
      if (sel1 != 5'd0) sel_nz = 1'b1;
      if (done1) begin
        d1cnt++;
        if (d1k < 0) d1k = k;
      end
      @(negedge clk);
    end
    tx_done1 = 1'b0;
    chk("one_nbytes", 64'(bytes1.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < bytes1.size())
        chk($sformatf("one_byte%0d", i), 64'(bytes1[i]), 64'(exp1[i]));
    end
    chk("one_done_cycle", 64'(d1k), 64'd11);
    chk("one_done_pulses", 64'(d1cnt), 64'd1);
    chk("one_sel_nonzero", 64'(sel_nz), 64'd0);
    chk("one_idle_after", 64'(busy1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
